// File: rtl/axi_slave_ram.sv
// AXI-style slave memory model: byte-strobed write bursts with a response
// channel, an in-order queue of outstanding read bursts, wrap-around burst
// addressing and SLVERR reporting for bursts that start outside the window.
module axi_slave_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int ADDR_B    = 0,
    parameter int ADDR_E    = 2047,
    parameter int RDQ_DEPTH = 8
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [7:0]          WR_LEN,
    input  logic [ID_W-1:0]     WR_ID,
    input  logic                WR_ADDR_VALID,
    output logic                WR_ADDR_READY,
    input  logic [DATA_W-1:0]   WR_DATA,
    input  logic [DATA_W/8-1:0] WR_STRB,
    input  logic                WR_DATA_VALID,
    output logic                WR_DATA_READY,
    input  logic                WR_DATA_LAST,
    output logic [ID_W-1:0]     WR_BACK_ID,
    output logic [1:0]          WR_BACK_RESP,
    output logic                WR_BACK_VALID,
    input  logic                WR_BACK_READY,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    input  logic [7:0]          RD_LEN,
    input  logic [ID_W-1:0]     RD_ID,
    input  logic                RD_ADDR_VALID,
    output logic                RD_ADDR_READY,
    output logic [ID_W-1:0]     RD_BACK_ID,
    output logic [DATA_W-1:0]   RD_DATA,
    output logic [1:0]          RD_BACK_RESP,
    output logic                RD_DATA_LAST,
    output logic                RD_DATA_VALID,
    input  logic                RD_DATA_READY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = ADDR_E - ADDR_B + 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = $clog2(RDQ_DEPTH);

    localparam logic [ADDR_W-1:0] ADDR_B_L = ADDR_W'(ADDR_B);
    localparam logic [ADDR_W-1:0] ADDR_E_L = ADDR_W'(ADDR_E);
    localparam logic [ADDR_W-1:0] SPAN_L   = ADDR_W'(ADDR_E - ADDR_B);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Single unsigned compare covers both bounds of the valid window.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a - ADDR_B_L) <= SPAN_L;
    endfunction

    // Burst address step, wrapping from the last word back to the first.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_E_L) ? ADDR_B_L : a + ADDR_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - ADDR_B_L);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_len_q, wr_len_d;
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d;
    logic              wr_oor_q, wr_oor_d;
    logic              wr_last_err_q, wr_last_err_d;
    logic              wr_addr_ready_q, wr_addr_ready_d;
    logic              wr_data_ready_q, wr_data_ready_d;
    logic              wr_back_valid_q, wr_back_valid_d;
    logic              wr_addr_hs, wr_data_hs, wr_back_hs, wr_beat_last, mem_we;

    // Write FSM next state, burst bookkeeping and registered ready/valid.
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_addr_hs    = WR_ADDR_VALID && wr_addr_ready_q;
        wr_data_hs    = WR_DATA_VALID && wr_data_ready_q;
        wr_back_hs    = WR_BACK_READY && wr_back_valid_q;
        wr_beat_last  = (wr_cnt_q == wr_len_q);
        mem_we        = wr_data_hs && !wr_oor_q;

        w_state_d     = w_state_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        wr_cnt_d      = wr_cnt_q;
        wr_id_d       = wr_id_q;
        wr_oor_d      = wr_oor_q;
        wr_last_err_d = wr_last_err_q;

        case (w_state_q)
            W_IDLE: begin
                if (wr_addr_hs) begin
                    wr_addr_d     = WR_ADDR;
                    wr_len_d      = WR_LEN;
                    wr_id_d       = WR_ID;
                    wr_cnt_d      = '0;
                    wr_oor_d      = !in_range(WR_ADDR);
                    wr_last_err_d = 1'b0;
                    w_state_d     = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_data_hs) begin
                    wr_addr_d = next_addr(wr_addr_q);
                    wr_cnt_d  = wr_cnt_q + 8'd1;
                    // A misplaced LAST flags the burst but never shortens it.
                    if (WR_DATA_LAST != wr_beat_last) begin
                        wr_last_err_d = 1'b1;
                    end
                    if (wr_beat_last) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (wr_back_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        wr_addr_ready_d = (w_state_d == W_IDLE);
        wr_data_ready_d = (w_state_d == W_DATA);
        wr_back_valid_d = (w_state_d == W_RESP);
    end

    // Write FSM state and burst registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            w_state_q       <= W_IDLE;
            wr_addr_q       <= '0;
            wr_len_q        <= '0;
            wr_cnt_q        <= '0;
            wr_id_q         <= '0;
            wr_oor_q        <= 1'b0;
            wr_last_err_q   <= 1'b0;
            wr_addr_ready_q <= 1'b0;
            wr_data_ready_q <= 1'b0;
            wr_back_valid_q <= 1'b0;
        end else begin
            w_state_q       <= w_state_d;
            wr_addr_q       <= wr_addr_d;
            wr_len_q        <= wr_len_d;
            wr_cnt_q        <= wr_cnt_d;
            wr_id_q         <= wr_id_d;
            wr_oor_q        <= wr_oor_d;
            wr_last_err_q   <= wr_last_err_d;
            wr_addr_ready_q <= wr_addr_ready_d;
            wr_data_ready_q <= wr_data_ready_d;
            wr_back_valid_q <= wr_back_valid_d;
        end
    end

    // Byte-strobed memory write for each accepted in-range beat.
    // NOTE: the storage array has no reset on purpose; contents survive BUS_RST and the array can map to RAM.
    always_ff @(posedge BUS_CLK) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WR_STRB[i]) begin
                    mem[to_idx(wr_addr_q)][8*i +: 8] <= WR_DATA[8*i +: 8];
                end
            end
        end
    end

    assign WR_ADDR_READY = wr_addr_ready_q;
    assign WR_DATA_READY = wr_data_ready_q;
    assign WR_BACK_VALID = wr_back_valid_q;
    assign WR_BACK_ID    = wr_id_q;
    assign WR_BACK_RESP  = (wr_oor_q || wr_last_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Read request queue
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rdq_addr [RDQ_DEPTH];
    logic [7:0]        rdq_len  [RDQ_DEPTH];
    logic [ID_W-1:0]   rdq_id   [RDQ_DEPTH];
    logic              rdq_err  [RDQ_DEPTH];

    logic [PTR_W-1:0]  rdq_wr_ptr_q, rdq_wr_ptr_d;
    logic [PTR_W-1:0]  rdq_rd_ptr_q, rdq_rd_ptr_d;
    logic [PTR_W:0]    rdq_cnt_q, rdq_cnt_d;
    logic              rd_addr_ready_q, rd_addr_ready_d;
    logic              rdq_push, rdq_pop;

    // ------------------------------------------------------------------
    // Read engine output register
    // ------------------------------------------------------------------
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic [1:0]        rd_resp_q, rd_resp_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              rd_load;

    // Queue push/pop and read-beat selection: continue the current burst,
    // otherwise start the next queued one on the same edge (no bubble).
    always_comb begin
        rdq_push  = RD_ADDR_VALID && rd_addr_ready_q;
        rdq_pop   = 1'b0;
        rd_load   = 1'b0;

        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        rd_id_d    = rd_id_q;
        rd_resp_d  = rd_resp_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;

        if (!rd_valid_q || RD_DATA_READY) begin
            if (rd_valid_q && !rd_last_q) begin
                rd_load   = 1'b1;
                rd_addr_d = next_addr(rd_addr_q);
                rd_cnt_d  = rd_cnt_q + 8'd1;
            end else if (rdq_cnt_q != '0) begin
                rdq_pop   = 1'b1;
                rd_load   = 1'b1;
                rd_addr_d = rdq_addr[rdq_rd_ptr_q];
                rd_len_d  = rdq_len[rdq_rd_ptr_q];
                rd_id_d   = rdq_id[rdq_rd_ptr_q];
                rd_resp_d = rdq_err[rdq_rd_ptr_q] ? RESP_SLVERR : RESP_OKAY;
                rd_cnt_d  = '0;
            end else begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
            end
        end

        // The array is read before this edge's write lands, so a colliding
        // write is not visible in the beat loaded on the same edge.
        if (rd_load) begin
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_d == rd_len_d);
            rd_data_d  = (rd_resp_d == RESP_SLVERR) ? '0 : mem[to_idx(rd_addr_d)];
        end

        rdq_wr_ptr_d = rdq_push ? rdq_wr_ptr_q + PTR_W'(1) : rdq_wr_ptr_q;
        rdq_rd_ptr_d = rdq_pop  ? rdq_rd_ptr_q + PTR_W'(1) : rdq_rd_ptr_q;
        case ({rdq_push, rdq_pop})
            2'b10:   rdq_cnt_d = rdq_cnt_q + (PTR_W+1)'(1);
            2'b01:   rdq_cnt_d = rdq_cnt_q - (PTR_W+1)'(1);
            default: rdq_cnt_d = rdq_cnt_q;
        endcase
        rd_addr_ready_d = (rdq_cnt_d != (PTR_W+1)'(RDQ_DEPTH));
    end

    // Queue entry storage, written on each accepted read request.
    always_ff @(posedge BUS_CLK) begin
        if (rdq_push) begin
            rdq_addr[rdq_wr_ptr_q] <= RD_ADDR;
            rdq_len[rdq_wr_ptr_q]  <= RD_LEN;
            rdq_id[rdq_wr_ptr_q]   <= RD_ID;
            rdq_err[rdq_wr_ptr_q]  <= !in_range(RD_ADDR);
        end
    end

    // Queue pointers/count and read output registers.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            rdq_wr_ptr_q    <= '0;
            rdq_rd_ptr_q    <= '0;
            rdq_cnt_q       <= '0;
            rd_addr_ready_q <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
            rd_data_q       <= '0;
            rd_id_q         <= '0;
            rd_resp_q       <= '0;
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            rd_cnt_q        <= '0;
        end else begin
            rdq_wr_ptr_q    <= rdq_wr_ptr_d;
            rdq_rd_ptr_q    <= rdq_rd_ptr_d;
            rdq_cnt_q       <= rdq_cnt_d;
            rd_addr_ready_q <= rd_addr_ready_d;
            rd_valid_q      <= rd_valid_d;
            rd_last_q       <= rd_last_d;
            rd_data_q       <= rd_data_d;
            rd_id_q         <= rd_id_d;
            rd_resp_q       <= rd_resp_d;
            rd_addr_q       <= rd_addr_d;
            rd_len_q        <= rd_len_d;
            rd_cnt_q        <= rd_cnt_d;
        end
    end

    assign RD_ADDR_READY = rd_addr_ready_q;
    assign RD_DATA_VALID = rd_valid_q;
    assign RD_DATA_LAST  = rd_last_q;
    assign RD_DATA       = rd_data_q;
    assign RD_BACK_ID    = rd_id_q;
    assign RD_BACK_RESP  = rd_resp_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram with default parameters (32-bit data,
// words 0..2047, 8-entry read queue). Inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_axi_slave_ram;

    localparam int ADDR_E = 2047;
    localparam int ADDR_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wr_addr = '0;
    logic [7:0]  wr_len = '0;
    logic [3:0]  wr_id = '0;
    logic        wr_addr_valid = 1'b0;
    logic        wr_addr_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_data_valid = 1'b0;
    logic        wr_data_ready;
    logic        wr_data_last = 1'b0;
    logic [3:0]  wr_back_id;
    logic [1:0]  wr_back_resp;
    logic        wr_back_valid;
    logic        wr_back_ready = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [7:0]  rd_len = '0;
    logic [3:0]  rd_id = '0;
    logic        rd_addr_valid = 1'b0;
    logic        rd_addr_ready;
    logic [3:0]  rd_back_id;
    logic [31:0] rd_data;
    logic [1:0]  rd_back_resp;
    logic        rd_data_last;
    logic        rd_data_valid;
    logic        rd_data_ready = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_data [16];
    logic [1:0]  resp;
    logic [3:0]  bid;

    always #5 clk = ~clk;

    axi_slave_ram dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .WR_ADDR       (wr_addr),
        .WR_LEN        (wr_len),
        .WR_ID         (wr_id),
        .WR_ADDR_VALID (wr_addr_valid),
        .WR_ADDR_READY (wr_addr_ready),
        .WR_DATA       (wr_data),
        .WR_STRB       (wr_strb),
        .WR_DATA_VALID (wr_data_valid),
        .WR_DATA_READY (wr_data_ready),
        .WR_DATA_LAST  (wr_data_last),
        .WR_BACK_ID    (wr_back_id),
        .WR_BACK_RESP  (wr_back_resp),
        .WR_BACK_VALID (wr_back_valid),
        .WR_BACK_READY (wr_back_ready),
        .RD_ADDR       (rd_addr),
        .RD_LEN        (rd_len),
        .RD_ID         (rd_id),
        .RD_ADDR_VALID (rd_addr_valid),
        .RD_ADDR_READY (rd_addr_ready),
        .RD_BACK_ID    (rd_back_id),
        .RD_DATA       (rd_data),
        .RD_BACK_RESP  (rd_back_resp),
        .RD_DATA_LAST  (rd_data_last),
        .RD_DATA_VALID (rd_data_valid),
        .RD_DATA_READY (rd_data_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full write burst: beat i carries base+i; LAST is driven on beat last_at.
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                               input logic [31:0] base, input logic [3:0] strb, input int last_at,
                               output logic [1:0] b_resp, output logic [3:0] b_id);
        int t;
        wr_addr = addr; wr_len = len[7:0]; wr_id = id; wr_addr_valid = 1'b1;
        t = 0;
        while (wr_addr_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("aw_ready", wr_addr_ready, 1);
        @(negedge clk);
        wr_addr_valid = 1'b0;
        check("aw_ready_drop", wr_addr_ready, 0);
        check("w_ready_rise", wr_data_ready, 1);
        for (int i = 0; i <= len; i++) begin
            wr_data = base + i; wr_strb = strb; wr_data_last = (i == last_at); wr_data_valid = 1'b1;
            @(negedge clk);
            if (i < len) check("b_early", wr_back_valid, 0);
        end
        wr_data_valid = 1'b0; wr_data_last = 1'b0;
        check("b_valid", wr_back_valid, 1);
        check("w_ready_drop", wr_data_ready, 0);
        b_resp = wr_back_resp; b_id = wr_back_id;
        wr_back_ready = 1'b1;
        @(negedge clk);
        wr_back_ready = 1'b0;
        check("b_done", wr_back_valid, 0);
        check("aw_ready_back", wr_addr_ready, 1);
    endtask

    // Issue one read request and wait for its acceptance.
    task automatic read_issue(input logic [31:0] addr, input int len, input logic [3:0] id);
        int t;
        rd_addr = addr; rd_len = len[7:0]; rd_id = id; rd_addr_valid = 1'b1;
        t = 0;
        while (rd_addr_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("ar_ready", rd_addr_ready, 1);
        @(negedge clk);
        rd_addr_valid = 1'b0;
    endtask

    // Read burst on an idle engine, checking latency, data, LAST, ID, RESP.
    task automatic read_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                              input logic [1:0] exp_resp);
        rd_data_ready = 1'b1;
        read_issue(addr, len, id);
        check("r_not_yet", rd_data_valid, 0);
        @(negedge clk);
        for (int i = 0; i <= len; i++) begin
            check("r_valid", rd_data_valid, 1);
            check("r_data", rd_data, exp_data[i]);
            check("r_last", rd_data_last, (i == len));
            if (i == 0) begin
                check("r_id", rd_back_id, id);
                check("r_resp", rd_back_resp, exp_resp);
            end
            @(negedge clk);
        end
        check("r_end", rd_data_valid, 0);
        rd_data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_aw_ready", wr_addr_ready, 0);
        check("rst_ar_ready", rd_addr_ready, 0);
        check("rst_b_valid", wr_back_valid, 0);
        check("rst_r_valid", rd_data_valid, 0);
        check("rst_r_data", rd_data, 0);
        check("rst_b_resp", wr_back_resp, 0);
        rst = 1'b0;
        #1;
        check("rst_rel_aw", wr_addr_ready, 0);
        @(negedge clk);
        check("ready_aw_up", wr_addr_ready, 1);
        check("ready_ar_up", rd_addr_ready, 1);

        // Single write then read at 16
        write_burst(32'd16, 3, 4'h3, 32'hA0, 4'hF, 3, resp, bid);
        check("wr1_resp", resp, 2'b00);
        check("wr1_id", bid, 4'h3);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
        read_burst(32'd16, 3, 4'h7, 2'b00);

        // Byte strobes
        write_burst(32'd5, 0, 4'h1, 32'hFFFF_FFFF, 4'hF, 0, resp, bid);
        write_burst(32'd5, 0, 4'h1, 32'h1122_3344, 4'b0101, 0, resp, bid);
        check("strb_resp", resp, 2'b00);
        exp_data[0] = 32'hFF22_FF44;
        read_burst(32'd5, 0, 4'h2, 2'b00);

        // Wrap from the last word to the first
        write_burst(ADDR_E - 1, 3, 4'h4, 32'hB0, 4'hF, 3, resp, bid);
        check("wrap_resp", resp, 2'b00);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hB0 + i;
        read_burst(ADDR_E - 1, 3, 4'h4, 2'b00);
        exp_data[0] = 32'hB2; exp_data[1] = 32'hB3;
        read_burst(ADDR_B, 1, 4'h9, 2'b00);

        // Queue fill: 1 burst held in the output register plus 8 queued
        write_burst(32'd100, 8, 4'h0, 32'hC0, 4'hF, 8, resp, bid);
        rd_data_ready = 1'b0;
        for (int i = 0; i < 9; i++) read_issue(32'd100 + i, 0, i[3:0]);
        check("q_full", rd_addr_ready, 0);
        check("q_hold_valid", rd_data_valid, 1);
        check("q_hold_id", rd_back_id, 0);
        rd_data_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("q_valid", rd_data_valid, 1);
            check("q_id", rd_back_id, k[3:0]);
            check("q_data", rd_data, 32'hC0 + k);
            check("q_last", rd_data_last, 1);
            @(negedge clk);
            if (k == 0) check("q_ready_back", rd_addr_ready, 1);
        end
        check("q_drained", rd_data_valid, 0);
        rd_data_ready = 1'b0;

        // Out-of-range write leaves the aliased word untouched
        write_burst(32'd9, 0, 4'h5, 32'h99, 4'hF, 0, resp, bid);
        write_burst(ADDR_E + 10, 0, 4'h6, 32'hDEAD_BEEF, 4'hF, 0, resp, bid);
        check("oor_w_resp", resp, 2'b10);
        check("oor_w_id", bid, 4'h6);
        exp_data[0] = 32'h99;
        read_burst(32'd9, 0, 4'h1, 2'b00);

        // Early LAST: burst still runs 3 beats, response SLVERR
        write_burst(32'd200, 2, 4'h8, 32'hE0, 4'hF, 1, resp, bid);
        check("last_err_resp", resp, 2'b10);

        // Out-of-range read returns zero with SLVERR
        exp_data[0] = 32'h0;
        read_burst(ADDR_E + 10, 0, 4'hA, 2'b10);

        // Reset during beat 2 of an 8-beat read
        write_burst(32'd300, 7, 4'h2, 32'hD0, 4'hF, 7, resp, bid);
        rd_data_ready = 1'b1;
        read_issue(32'd300, 7, 4'h5);
        repeat (3) @(negedge clk);
        check("mid_beat2", rd_data, 32'hD2);
        rst = 1'b1;
        #1;
        check("mid_r_valid", rd_data_valid, 0);
        check("mid_r_data", rd_data, 0);
        check("mid_r_id", rd_back_id, 0);
        check("mid_r_last", rd_data_last, 0);
        check("mid_r_resp", rd_back_resp, 0);
        check("mid_ar_ready", rd_addr_ready, 0);
        check("mid_aw_ready", wr_addr_ready, 0);
        rd_data_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_ar_ready", rd_addr_ready, 1);
        check("post_empty1", rd_data_valid, 0);
        @(negedge clk);
        check("post_empty2", rd_data_valid, 0);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hD0 + i;
        read_burst(32'd300, 3, 4'h6, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
